// File: rtl/booth_pkg.sv
// Shared types and build-time constants for the sequential Booth multiplier.
// Holds the FSM state enum, the Booth digit enum and the iteration helper.
// Build option: BOOTH_RADIX4_EN selects radix-4 recoding (two bits per step);
// when undefined the multiplier retires one bit per step (radix-2).
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Signed Booth digit applied to the multiplicand in one step.
    typedef enum logic [2:0] {
        ZERO = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        M1   = 3'd3,
        M2   = 3'd4
    } digit_e;

`ifdef BOOTH_RADIX4_EN
    // Multiplier bits retired per step and recode window {Q[1], Q[0], q_prev}.
    localparam int SHIFT       = 2;
    localparam int RECODE_BITS = 3;
`else
    // One bit per step; recode window {Q[0], q_prev}.
    localparam int SHIFT       = 1;
    localparam int RECODE_BITS = 2;
`endif

    // Number of RUN cycles needed to consume a width-bit multiplier.
    function automatic int iter_count(input int width);
`ifdef BOOTH_RADIX4_EN
        return width / 2;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/booth_recoder.sv
// Combinational Booth recoder: maps the recode window to a digit and
// returns the matching addend (0, +-M, +-2M) at accumulator width.
// Ports: bits_i recode window, m_ext_i sign-extended multiplicand,
//        addend_o value added to the accumulator this step.
// Build option: BOOTH_RADIX4_EN widens the window to three bits.
module booth_recoder
    import booth_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic [RECODE_BITS-1:0] bits_i,
    input  logic [WIDTH+1:0]       m_ext_i,
    output logic [WIDTH+1:0]       addend_o
);

    digit_e dig;

    always_comb begin
        dig = ZERO;
`ifdef BOOTH_RADIX4_EN
        unique case (bits_i)
            3'b001,
            3'b010:  dig = P1;
            3'b011:  dig = P2;
            3'b100:  dig = M2;
            3'b101,
            3'b110:  dig = M1;
            default: dig = ZERO;
        endcase
`else
        unique case (bits_i)
            2'b01:   dig = P1;
            2'b10:   dig = M1;
            default: dig = ZERO;
        endcase
`endif
    end

    // Two guard bits in the accumulator keep -2M of the most negative
    // operand representable.
    always_comb begin
        addend_o = '0;
        unique case (dig)
            ZERO:    addend_o = '0;
            P1:      addend_o = m_ext_i;
            P2:      addend_o = m_ext_i << 1;
            M1:      addend_o = -m_ext_i;
            M2:      addend_o = -(m_ext_i << 1);
            default: addend_o = '0;
        endcase
    end

endmodule

// File: rtl/booth_seq_mult.sv
// Multi-cycle signed Booth multiplier: one Booth digit per clock.
// Ports: clk, rst (sync, active-high); start with multiplicand/multiplier
//        operands; busy high in RUN; done one-cycle pulse; product 2*WIDTH.
// Build option: BOOTH_RADIX4_EN halves the iteration count (radix-4).
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int ITER = iter_count(WIDTH);
    localparam int CW   = $clog2(ITER + 1);
    localparam int AW   = WIDTH + 2;
    localparam int RW   = AW + WIDTH + 1;

    localparam logic [CW-1:0] ITER_C = CW'(ITER);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    state_e             state_q, state_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic               qp_q, qp_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    logic [AW-1:0]          m_ext;
    logic [AW-1:0]          addend;
    logic [AW-1:0]          sum;
    logic [RW-1:0]          shifted;
    logic [RECODE_BITS-1:0] rbits;

    assign m_ext = {{2{m_q[WIDTH-1]}}, m_q};
    assign rbits = {q_q[RECODE_BITS-2:0], qp_q};

    booth_recoder #(
        .WIDTH (WIDTH)
    ) u_recoder (
        .bits_i   (rbits),
        .m_ext_i  (m_ext),
        .addend_o (addend)
    );

    assign sum = acc_q + addend;

    // {acc, Q, q_prev} shifts as one signed register; the accumulator
    // sign fills from the top.
    assign shifted = $signed({sum, q_q, qp_q}) >>> SHIFT;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        q_d     = q_q;
        qp_d    = qp_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    m_d     = multiplicand;
                    q_d     = multiplier;
                    acc_d   = '0;
                    qp_d    = 1'b0;
                    cnt_d   = ITER_C;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = shifted[RW-1:WIDTH+1];
                q_d   = shifted[WIDTH:1];
                qp_d  = shifted[0];
                cnt_d = cnt_q - ONE_C;
                if (cnt_q == ONE_C) begin
                    state_d = DONE;
                    // Low 2*WIDTH bits of {acc, Q} after the final shift.
                    prod_d  = shifted[2*WIDTH:1];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            q_q     <= '0;
            qp_q    <= 1'b0;
            m_q     <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            qp_q    <= qp_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = prod_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed bench for booth_seq_mult at WIDTH=6 and WIDTH=8.
// Honours BOOTH_RADIX4_EN for the expected latency.
module tb_booth_seq_mult;

`ifdef BOOTH_RADIX4_EN
    localparam int ITER6 = 3;
    localparam int ITER8 = 4;
`else
    localparam int ITER6 = 6;
    localparam int ITER8 = 8;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        st6, bz6, dn6;
    logic [5:0]  a6, b6;
    logic [11:0] p6;
    logic        st8, bz8, dn8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    int n_chk  = 0;
    int n_pass = 0;

    booth_seq_mult #(.WIDTH(6)) dut6 (
        .clk          (clk),
        .rst          (rst),
        .start        (st6),
        .multiplicand (a6),
        .multiplier   (b6),
        .busy         (bz6),
        .done         (dn6),
        .product      (p6)
    );

    booth_seq_mult #(.WIDTH(8)) dut8 (
        .clk          (clk),
        .rst          (rst),
        .start        (st8),
        .multiplicand (a8),
        .multiplier   (b8),
        .busy         (bz8),
        .done         (dn8),
        .product      (p8)
    );

    task automatic check(input string tag,
                         input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic mul6(input logic signed [5:0]  m,
                        input logic signed [5:0]  q,
                        input logic signed [63:0] exp,
                        input string              tag,
                        input bit                 full);
        int lat;
        int nbusy;
        @(negedge clk);
        a6 = m; b6 = q; st6 = 1'b1;
        @(negedge clk);
        st6 = 1'b0; a6 = ~m; b6 = ~q;
        lat = 1; nbusy = 0;
        while (!dn6 && lat < 40) begin
            if (bz6) nbusy++;
            @(negedge clk);
            lat++;
        end
        check({tag, ":done"}, dn6, 1);
        check({tag, ":prod"}, $signed(p6), exp);
        if (full) begin
            check({tag, ":lat"}, lat, ITER6 + 1);
            check({tag, ":nbusy"}, nbusy, ITER6);
            check({tag, ":busy@done"}, bz6, 0);
            @(negedge clk);
            check({tag, ":pulse"}, dn6, 0);
            check({tag, ":hold"}, $signed(p6), exp);
        end
    endtask

    task automatic mul8(input logic signed [7:0]  m,
                        input logic signed [7:0]  q,
                        input logic signed [63:0] exp,
                        input string              tag);
        int lat;
        @(negedge clk);
        a8 = m; b8 = q; st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0; a8 = ~m; b8 = ~q;
        lat = 1;
        while (!dn8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ":lat"}, lat, ITER8 + 1);
        check({tag, ":prod"}, $signed(p8), exp);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int ndone;
        logic signed [63:0] pd;
        logic signed [7:0]  rm, rq;

        rst = 1'b1;
        st6 = 1'b0; a6 = '0; b6 = '0;
        st8 = 1'b0; a8 = '0; b8 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst:busy", bz6, 0);
        check("rst:done", dn6, 0);
        check("rst:prod", p6, 0);
        check("rst8:prod", p8, 0);

        mul6(6, 2, 12, "6x2", 1);
        mul6(-3, 5, -15, "-3x5", 1);
        mul6(-7, -6, 42, "-7x-6", 1);
        mul6(-15, 30, -450, "-15x30", 1);
        mul6(30, -15, -450, "30x-15", 1);
        mul6(-32, -32, 1024, "-32x-32", 1);
        mul6(-32, 31, -992, "-32x31", 1);

        // Back-to-back with start held high.
        @(negedge clk);
        a6 = 15; b6 = 15; st6 = 1'b1;
        @(negedge clk);
        cnt = 1;
        while (!dn6 && cnt < 40) begin @(negedge clk); cnt++; end
        check("b2b:lat1", cnt, ITER6 + 1);
        check("b2b:prod1", $signed(p6), 225);
        a6 = -16; b6 = -16;
        @(negedge clk);
        st6 = 1'b0;
        cnt = 1;
        while (!dn6 && cnt < 40) begin @(negedge clk); cnt++; end
        check("b2b:space", cnt, ITER6 + 1);
        check("b2b:prod2", $signed(p6), 256);
        @(negedge clk);

        // Start pulsed mid-RUN must be ignored.
        @(negedge clk);
        a6 = 3; b6 = 5; st6 = 1'b1;
        @(negedge clk);
        ndone = 0; pd = '0;
        for (int k = 1; k <= 2 * ITER6 + 4; k++) begin
            if (k == 2) begin st6 = 1'b1; a6 = 7; b6 = 7; end
            else st6 = 1'b0;
            if (dn6) begin ndone++; pd = $signed(p6); end
            @(negedge clk);
        end
        check("midrun:ndone", ndone, 1);
        check("midrun:prod", pd, 15);
        check("midrun:hold", $signed(p6), 15);

        // Reset in the second RUN cycle, with a simultaneous start.
        @(negedge clk);
        a6 = -7; b6 = -6; st6 = 1'b1;
        @(negedge clk);
        st6 = 1'b0;
        @(negedge clk);
        rst = 1'b1; st6 = 1'b1;
        @(negedge clk);
        rst = 1'b0; st6 = 1'b0;
        check("abort:busy", bz6, 0);
        check("abort:done", dn6, 0);
        check("abort:prod", p6, 0);
        ndone = 0;
        repeat (ITER6 + 2) begin
            @(negedge clk);
            if (dn6 || bz6) ndone++;
        end
        check("abort:quiet", ndone, 0);
        mul6(-7, -6, 42, "post-rst", 1);

        for (int i = -32; i < 32; i++)
            for (int j = -32; j < 32; j++)
                mul6(6'(i), 6'(j), 64'(i * j),
                     $sformatf("exh %0d*%0d", i, j), 0);

        mul8(-128, 127, -16256, "w8 -128x127");
        mul8(-128, -128, 16384, "w8 -128x-128");
        mul8(127, 127, 16129, "w8 127x127");
        for (int n = 0; n < 200; n++) begin
            rm = 8'($urandom);
            rq = 8'($urandom);
            mul8(rm, rq, 64'(rm) * 64'(rq),
                 $sformatf("w8 rnd %0d*%0d", rm, rq));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
